// File: rtl/cla_serial_adder.sv
// Multi-byte serial adder/subtractor: one 8-bit CLA slice per cycle.
// Ports: clk, rst, start, sub, cin, a, b -> busy, done, sum, cout, ovf.
module cla_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          cy;
  logic [IW-1:0] idx;
  logic [IW+2:0] off;

  logic [7:0]    ba;
  logic [7:0]    bb;
  logic [7:0]    p;
  logic [7:0]    g;
  logic [7:0]    c;
  logic          c8;
  logic [7:0]    s;

  assign off = {idx, 3'b000};
  assign ba  = opa[off +: 8];
  assign bb  = opb[off +: 8];
  assign p   = ba ^ bb;
  assign g   = ba & bb;

  // Carry cells: c(i+1) = g_i | p_i & c_i, walked through a temp
  // so no vector element is read and written in the same block.
  always_comb begin
    logic cc;
    cc = cy;
    c  = '0;
    for (int i = 0; i < 8; i++) begin
      c[i] = cc;
      cc   = g[i] | (p[i] & cc);
    end
    c8 = cc;
    s  = p ^ c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      cy    <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            // Subtract as a + ~b + 1.
            opb   <= b ^ {W{sub}};
            cy    <= sub | cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[off +: 8] <= s;
          cy            <= c8;
          if (idx == LAST) begin
            cout  <= c8;
            ovf   <= c[7] ^ c8;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder (NBYTES=4).
// Drives on negedge, samples on negedge, counts vectors and miscompares.
module tb_cla_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vectors;
  int miscompares;

  cla_serial_adder #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op from IDLE, scramble inputs after acceptance,
  // then wait (bounded) for done. lat counts cycles after start.
  task automatic launch(
    input  logic [W-1:0] ai,
    input  logic [W-1:0] bi,
    input  logic         si,
    input  logic         ci,
    output int           lat,
    output int           bcnt
  );
    @(negedge clk);
    a     = ai;
    b     = bi;
    sub   = si;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ai;
    b     = ~bi;
    sub   = ~si;
    cin   = ~ci;
    lat   = 0;
    bcnt  = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, cout, ovf} !== 4'b0 || sum !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%0b done=%0b sum=%h cout=%0b ovf=%0b, want all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_mid_run_reset;
    int lat;
    int bcnt;
    int stray;
    @(negedge clk);
    a     = 32'h1234_5678;
    b     = 32'h1111_1111;
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, cout, ovf} !== 4'b0 || sum !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%0b done=%0b sum=%h cout=%0b ovf=%0b, want all 0",
               busy, done, sum, cout, ovf);
    end
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL midrun_idle: busy/done seen %0d cycles, want 0", stray);
    end
    launch(32'h1, 32'h1, 1'b0, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== NB + 1 || sum !== 32'h2) begin
      miscompares++;
      $display("FAIL after_reset_op: lat=%0d sum=%h, want lat=%0d sum=00000002",
               lat, sum, NB + 1);
    end
  endtask

  task automatic test_ripple;
    int lat;
    int bcnt;
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== 5 || bcnt !== 4) begin
      miscompares++;
      $display("FAIL ripple_latency: lat=%0d busy=%0d, want lat=5 busy=4", lat, bcnt);
    end
    vectors++;
    if (sum !== 32'h0000_0100 || cout !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_sum: sum=%h cout=%0b ovf=%0b, want 00000100 0 0",
               sum, cout, ovf);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%0b one cycle later, want 0", done);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (sum !== 32'h0000_0100 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sum_hold: sum=%h busy=%0b, want 00000100 0", sum, busy);
    end
  endtask

  task automatic test_wrap;
    int lat;
    int bcnt;
    launch(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, lat, bcnt);
    vectors++;
    if (lat !== 5 || sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: lat=%0d sum=%h cout=%0b ovf=%0b, want 5 00000000 1 0",
               lat, sum, cout, ovf);
    end
  endtask

  task automatic test_overflow;
    int lat;
    int bcnt;
    launch(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== 5 || sum !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: lat=%0d sum=%h cout=%0b ovf=%0b, want 5 80000000 0 1",
               lat, sum, cout, ovf);
    end
  endtask

  task automatic test_subtract;
    int lat;
    int bcnt;
    launch(32'd5, 32'd7, 1'b1, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== 5 || sum !== 32'hFFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow: lat=%0d sum=%h cout=%0b ovf=%0b, want 5 fffffffe 0 0",
               lat, sum, cout, ovf);
    end
    launch(32'h8000_0000, 32'h1, 1'b1, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== 5 || sum !== 32'h7FFF_FFFF || cout !== 1'b1 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_ovf: lat=%0d sum=%h cout=%0b ovf=%0b, want 5 7fffffff 1 1",
               lat, sum, cout, ovf);
    end
    launch(32'h0001_0000, 32'h1, 1'b1, 1'b1, lat, bcnt);
    vectors++;
    if (sum !== 32'h0000_FFFF || cout !== 1'b1 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_cin_ignored: sum=%h cout=%0b ovf=%0b, want 0000ffff 1 0",
               sum, cout, ovf);
    end
  endtask

  // start held high: ops accepted at t=0,6,12; done at t=5,11,17.
  task automatic test_back_to_back;
    logic [W-1:0] exp_sum [3];
    logic         exp_busy;
    logic         exp_done;
    int           ph;
    exp_sum[0] = 32'd3;
    exp_sum[1] = 32'd30;
    exp_sum[2] = 32'd300;
    @(negedge clk);
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    for (int t = 0; t < 18; t++) begin
      if (t > 0) @(negedge clk);
      ph       = t % 6;
      exp_busy = (ph >= 1 && ph <= 4);
      exp_done = (ph == 5);
      vectors++;
      if (busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL b2b_ctrl t=%0d: busy=%0b done=%0b, want %0b %0b",
                 t, busy, done, exp_busy, exp_done);
      end
      if (exp_done) begin
        vectors++;
        if (sum !== exp_sum[t / 6]) begin
          miscompares++;
          $display("FAIL b2b_sum t=%0d: sum=%h, want %h", t, sum, exp_sum[t / 6]);
        end
      end
      if (ph == 0) begin
        unique case (t / 6)
          0: begin a = 32'd1;   b = 32'd2;   end
          1: begin a = 32'd10;  b = 32'd20;  end
          default: begin a = 32'd100; b = 32'd200; end
        endcase
      end else begin
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(1));
      end
      if (ph == 5) sub = 1'b0;
      if (t == 17) start = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop: busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mid_run_reset();
    test_ripple();
    test_wrap();
    test_overflow();
    test_subtract();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
